lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Sequencer for the character LCD port of the single-cycle core's I/O block. Runs the HD44780 power-on initialisation by itself after reset, then accepts single-byte command and data writes from the LSU-side I/O logic over a valid/ready handshake. For each write it drives RS, data and the EN strobe with programmable setup, pulse, hold and execution waits. Its packed output replaces the raw register that currently feeds o_io_lcd.

## Interface
- T_PWRUP, default 750000: power-up wait in cycles before the first init command (15 ms at 50 MHz).
- T_SETUP, default 4: cycles RS and data are stable before EN rises.
- T_EN, default 12: EN high time in cycles.
- T_HOLD, default 4: cycles RS and data stay stable after EN falls.
- T_CMD, default 2500: execution wait for normal commands and data writes.
- T_CLR, default 82000: execution wait for clear (0x01) and home (0x02/0x03) commands with RS=0.
- All parameters are ≥1.

- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_req  in  1  write request (valid).
- i_rs  in  1  0 = command, 1 = data.
- i_data  in  8  byte to write.
- o_ready  out  1  controller idle and able to accept a write.
- o_init_done  out  1  init sequence complete; sticky until reset.
- o_lcd  out  32  packed LCD bus: [31] ON, [30:11] zero, [10] EN, [9] RS, [8] RW (always 0), [7:0] DATA.

## Operation
- States: PWRUP, SETUP, EN_HI, HOLD, WAIT, IDLE.
- An init ROM index 0..5 holds the sequence 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all with RS=0.
- PWRUP: count T_PWRUP cycles, load init entry 0, then go to SETUP.
- SETUP: EN=0, RS and DATA driven from the latched byte, for T_SETUP cycles, then go to EN_HI.
- EN_HI: EN=1 for T_EN cycles, then go to HOLD.
- HOLD: EN=0, RS and DATA unchanged, for T_HOLD cycles, then go to WAIT.
- WAIT: count T_CLR if the latched RS=0 and the latched byte is 0x01, 0x02 or 0x03; otherwise count T_CMD. Then:
  - during init with index <5: increment the index and go to SETUP;
  - at index 5: set o_init_done and go to IDLE;
  - after init: go to IDLE.
- IDLE: o_ready=1. When i_req && o_ready is sampled on an edge, latch i_rs and i_data and go to SETUP.
- i_req in any other state is ignored; nothing is queued and no error is flagged.
- DATA and RS hold their last values in IDLE and WAIT. They change only on the acceptance edge or on an init-index load.
- ON is 1 in every state and 0 only while in reset.
- A single down-counter serves all timed states. Size it to the widest of T_PWRUP, T_CLR and T_CMD.

## Timing
- Reset values: o_lcd=0x0000_0000, o_ready=0, o_init_done=0, state=PWRUP, init index=0.
- Reset asserted mid-operation (including with EN=1) forces the reset values at the next edge. When reset is released, the full init sequence restarts.
- Define edge 0 as the first edge with i_rst_n=1.
  - o_lcd[31] is 1 from edge 0.
  - The first EN rise occurs at edge T_PWRUP+T_SETUP.
- o_init_done and o_ready rise together at edge T_PWRUP + 5·(T_SETUP+T_EN+T_HOLD+T_CMD) + (T_SETUP+T_EN+T_HOLD+T_CLR).
- For a write accepted at edge N:
  - o_ready=0 from edge N.
  - EN=1 from edge N+T_SETUP through N+T_SETUP+T_EN−1.
  - o_ready returns to 1 at edge N+T_SETUP+T_EN+T_HOLD+Twait, where Twait is T_CMD or T_CLR.
- Back-to-back writes: if i_req is held high, the next write is accepted on the same edge o_ready becomes visible high. This gives one idle cycle between writes.
- Only one EN pulse per write. EN never glitches between writes.

## Test plan
Parameters for all scenarios: T_PWRUP=20, T_SETUP=2, T_EN=4, T_HOLD=2, T_CMD=10, T_CLR=30.
- Reset then release, no requests -> six EN pulses carrying DATA 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0. First EN at edge 22. o_init_done and o_ready rise at edge 148. o_lcd[31]=1 throughout.
- After init, a data write i_rs=1, i_data=0x41 accepted at edge N -> o_lcd[9:0]=0x241 from N. EN high for edges N+2..N+5. o_ready is 1 again at N+18.
- A command write i_rs=0, i_data=0x01, and separately 0x02 -> each gives o_ready back at N+38. Command 0x80 gives o_ready back at N+18.
- i_req pulsed with 0x55 while busy at N+3, followed by a held request of 0x42 -> the 0x55 pulse never produces an EN pulse. 0x42 is accepted on the o_ready edge and gets exactly one EN pulse.
- Reset asserted during EN_HI of the init 0x0C write -> at the next edge o_lcd=0 and o_ready=0. After release, init restarts from 0x38 and completes 148 edges later.
- Throughout all scenarios, the checker verifies: o_lcd[30:11]=0, RW=0, and RS/DATA stable from SETUP through HOLD.

Source files
------------

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 character LCD sequencer with power-on init and byte write handshake
module lcd_ctrl #(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 4,
  parameter int unsigned T_CMD   = 2500,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_rs,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  output logic        o_init_done,
  output logic [31:0] o_lcd
);

  localparam int unsigned T_MAX_A = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int unsigned T_MAX   = (T_MAX_A > T_CMD) ? T_MAX_A : T_CMD;
  localparam int unsigned CW      = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic          rs, rs_nx;
  logic [7:0]    data, data_nx;
  logic          done, done_nx;
  logic          on;
  logic          slow_cmd;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: init_byte = 8'h38;
      3'd3:             init_byte = 8'h0C;
      3'd4:             init_byte = 8'h01;
      3'd5:             init_byte = 8'h06;
      default:          init_byte = 8'h00;
    endcase
  endfunction

  // Clear and home need the long execution wait; everything else uses T_CMD.
  assign slow_cmd = !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    rs_nx    = rs;
    data_nx  = data;
    done_nx  = done;
    case (state)
      S_PWRUP: begin
        if (cnt == '0) begin
          state_nx = S_SETUP;
          cnt_nx   = CW'(T_SETUP - 1);
          idx_nx   = 3'd0;
          rs_nx    = 1'b0;
          data_nx  = init_byte(3'd0);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_nx = S_EN_HI;
          cnt_nx   = CW'(T_EN - 1);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_EN_HI: begin
        if (cnt == '0) begin
          state_nx = S_HOLD;
          cnt_nx   = CW'(T_HOLD - 1);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_nx = S_WAIT;
          cnt_nx   = slow_cmd ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          if (!done && idx != 3'd5) begin
            state_nx = S_SETUP;
            cnt_nx   = CW'(T_SETUP - 1);
            idx_nx   = idx + 3'd1;
            rs_nx    = 1'b0;
            data_nx  = init_byte(idx + 3'd1);
          end else begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_IDLE: begin
        if (i_req) begin
          state_nx = S_SETUP;
          cnt_nx   = CW'(T_SETUP - 1);
          rs_nx    = i_rs;
          data_nx  = i_data;
        end
      end
      default: begin
        state_nx = S_PWRUP;
        cnt_nx   = CW'(T_PWRUP);
      end
    endcase
  end

  // Loading T_PWRUP (not T_PWRUP-1) makes the first SETUP start exactly T_PWRUP edges after release.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_PWRUP;
      cnt   <= CW'(T_PWRUP);
      idx   <= 3'd0;
      rs    <= 1'b0;
      data  <= 8'h00;
      done  <= 1'b0;
      on    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      rs    <= rs_nx;
      data  <= data_nx;
      done  <= done_nx;
      on    <= 1'b1;
    end
  end

  assign o_ready     = (state == S_IDLE);
  assign o_init_done = done;
  assign o_lcd       = {on, 20'h00000, (state == S_EN_HI), rs, 1'b0, data};

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed self-checking bench for lcd_ctrl
module tb_lcd_ctrl;

  localparam int TP = 20;
  localparam int TS = 2;
  localparam int TE = 4;
  localparam int TH = 2;
  localparam int TC = 10;
  localparam int TL = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        rs = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        ready;
  logic        init_done;
  logic [31:0] lcd;

  int checks = 0;
  int errors = 0;
  int e = -1;
  logic [8:0] en_log[$];
  logic [7:0] exp_init[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_ctrl #(
    .T_PWRUP(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_CMD(TC), .T_CLR(TL)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .i_rs(rs),
    .i_data(data),
    .o_ready(ready),
    .o_init_done(init_done),
    .o_lcd(lcd)
  );

  always #5 clk = ~clk;

  // Bus invariants and RS/DATA stability around every EN pulse, sampled 2 time units after each edge.
  logic [9:0] prev_bus, prev2_bus;
  logic       prev_en = 1'b0;
  int         valid_cnt = 0;
  int         en_len = 0;
  int         since_fall = 99;

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      checks++;
      if (lcd !== 32'h0) begin
        errors++;
        $display("FAIL reset_bus actual=%h required=00000000", lcd);
      end
      valid_cnt = 0;
      prev_en = 1'b0;
      en_len = 0;
      since_fall = 99;
    end else begin
      checks++;
      if (lcd[31] !== 1'b1 || lcd[30:11] !== 20'h0 || lcd[8] !== 1'b0) begin
        errors++;
        $display("FAIL bus_fixed_bits actual=%h required=on=1 zero[30:11] rw=0", lcd);
      end
      if (valid_cnt >= 2) begin
        if (lcd[10] && !prev_en) begin
          checks++;
          if (lcd[9:0] !== prev_bus || lcd[9:0] !== prev2_bus) begin
            errors++;
            $display("FAIL setup_stable actual=%h prev=%h prev2=%h", lcd[9:0], prev_bus, prev2_bus);
          end
          en_log.push_back({lcd[9], lcd[7:0]});
        end
        if (lcd[10] && prev_en) begin
          checks++;
          if (lcd[9:0] !== prev_bus) begin
            errors++;
            $display("FAIL en_stable actual=%h required=%h", lcd[9:0], prev_bus);
          end
        end
        if (!lcd[10] && prev_en) begin
          checks++;
          if (en_len !== TE || lcd[9:0] !== prev_bus) begin
            errors++;
            $display("FAIL en_width_hold actual=len%0d bus%h required=len%0d bus%h", en_len, lcd[9:0], TE, prev_bus);
          end
          since_fall = 1;
        end else if (!lcd[10] && since_fall < TH) begin
          checks++;
          if (lcd[9:0] !== prev_bus) begin
            errors++;
            $display("FAIL hold_stable actual=%h required=%h", lcd[9:0], prev_bus);
          end
          since_fall++;
        end
      end
      en_len = lcd[10] ? en_len + 1 : 0;
      prev2_bus = prev_bus;
      prev_bus = lcd[9:0];
      prev_en = lcd[10];
      valid_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    e++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (lcd !== 32'h0 || ready !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state actual=lcd%h rdy%b done%b required=lcd00000000 rdy0 done0", lcd, ready, init_done);
    end
    rst_n = 1'b1;
    e = -1;
  endtask

  task automatic test_init(input string name);
    en_log.delete();
    while (e < 148) begin
      tick();
      if (e == 0) begin
        checks++;
        if (lcd[31] !== 1'b1 || ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_edge0 actual=on%b rdy%b required=on1 rdy0", name, lcd[31], ready);
        end
      end
      if (e == 21) begin
        checks++;
        if (lcd[10] !== 1'b0) begin
          errors++;
          $display("FAIL %s_en_early actual=%b required=0", name, lcd[10]);
        end
      end
      if (e == 22) begin
        checks++;
        if (lcd[10] !== 1'b1 || lcd[9:0] !== 10'h038) begin
          errors++;
          $display("FAIL %s_first_en actual=en%b bus%h required=en1 bus038", name, lcd[10], lcd[9:0]);
        end
      end
      if (e == 147) begin
        checks++;
        if (ready !== 1'b0 || init_done !== 1'b0) begin
          errors++;
          $display("FAIL %s_done_early actual=rdy%b done%b required=rdy0 done0", name, ready, init_done);
        end
      end
    end
    checks++;
    if (ready !== 1'b1 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done actual=rdy%b done%b required=rdy1 done1", name, ready, init_done);
    end
    checks++;
    if (en_log.size() !== 6) begin
      errors++;
      $display("FAIL %s_pulse_count actual=%0d required=6", name, en_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (en_log[i] !== {1'b0, exp_init[i]}) begin
          errors++;
          $display("FAIL %s_rom%0d actual=%h required=%h", name, i, en_log[i], {1'b0, exp_init[i]});
        end
      end
    end
  endtask

  task automatic do_write(input logic w_rs, input logic [7:0] w_data, input int twait, input string name);
    int n;
    int total;
    int pre;
    pre = en_log.size();
    total = TS + TE + TH + twait;
    req = 1'b1;
    rs = w_rs;
    data = w_data;
    tick();
    n = e;
    req = 1'b0;
    checks++;
    if (ready !== 1'b0 || lcd[9:0] !== {w_rs, 1'b0, w_data}) begin
      errors++;
      $display("FAIL %s_accept actual=rdy%b bus%h required=rdy0 bus%h", name, ready, lcd[9:0], {w_rs, 1'b0, w_data});
    end
    while (e < n + total) begin
      tick();
      if (e == n + 1 || e == n + 6) begin
        checks++;
        if (lcd[10] !== 1'b0) begin
          errors++;
          $display("FAIL %s_en_low e=N+%0d actual=%b required=0", name, e - n, lcd[10]);
        end
      end
      if (e == n + 2 || e == n + 5) begin
        checks++;
        if (lcd[10] !== 1'b1) begin
          errors++;
          $display("FAIL %s_en_high e=N+%0d actual=%b required=1", name, e - n, lcd[10]);
        end
      end
      if (e == n + total - 1) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_ready_early actual=%b required=0", name, ready);
        end
      end
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_back actual=%b required=1", name, ready);
    end
    checks++;
    if (en_log.size() !== pre + 1 || en_log[en_log.size() - 1] !== {w_rs, w_data}) begin
      errors++;
      $display("FAIL %s_pulse actual=count%0d required=count%0d", name, en_log.size() - pre, 1);
    end
  endtask

  task automatic test_data_write();
    do_write(1'b1, 8'h41, TC, "data_41");
  endtask

  task automatic test_clr_home();
    do_write(1'b0, 8'h01, TL, "cmd_clear");
    do_write(1'b0, 8'h02, TL, "cmd_home");
    do_write(1'b0, 8'h80, TC, "cmd_80");
  endtask

  task automatic test_back_to_back();
    int n;
    int pre;
    int guard;
    pre = en_log.size();
    req = 1'b1;
    rs = 1'b1;
    data = 8'h30;
    tick();
    n = e;
    req = 1'b0;
    tick();
    tick();
    req = 1'b1;
    rs = 1'b0;
    data = 8'h55;
    tick();
    req = 1'b0;
    tick();
    req = 1'b1;
    rs = 1'b1;
    data = 8'h42;
    guard = 0;
    while (!ready && guard < 100) begin
      tick();
      guard++;
    end
    checks++;
    if (e !== n + 18) begin
      errors++;
      $display("FAIL b2b_ready_edge actual=N+%0d required=N+18", e - n);
    end
    tick();
    req = 1'b0;
    checks++;
    if (ready !== 1'b0 || lcd[9:0] !== 10'h242) begin
      errors++;
      $display("FAIL b2b_accept actual=rdy%b bus%h required=rdy0 bus242", ready, lcd[9:0]);
    end
    guard = 0;
    while (!ready && guard < 100) begin
      tick();
      guard++;
    end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL b2b_timeout actual=rdy%b required=1", ready);
    end
    checks++;
    if (en_log.size() !== pre + 2 || en_log[pre] !== 9'h130 || en_log[pre + 1] !== 9'h142) begin
      errors++;
      $display("FAIL b2b_pulses actual=count%0d required=2 (130,142)", en_log.size() - pre);
    end
  endtask

  task automatic test_reset_mid_en();
    int guard;
    do_reset();
    guard = 0;
    while (!(lcd[10] === 1'b1 && lcd[7:0] === 8'h0C) && guard < 200) begin
      tick();
      guard++;
    end
    checks++;
    if (e !== 76) begin
      errors++;
      $display("FAIL mid_en_edge actual=%0d required=76", e);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (lcd !== 32'h0 || ready !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset actual=lcd%h rdy%b done%b required=lcd00000000 rdy0 done0", lcd, ready, init_done);
    end
    tick();
    rst_n = 1'b1;
    e = -1;
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_data_write();
    test_clr_home();
    test_back_to_back();
    test_reset_mid_en();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
